ctrl_pipe_exc: RTL and testbench
================================

// Module: ctrl_pipe_exc
// PURPOSE
//  Parametrised control-signal pipeline for the MIPS core. Takes the decoded control bundle
//  and trap tags from decode, and carries them through NSTG stages (E, M, W by default).
//  Each stage has its own stall and flush. Exceptions and ERET are handled precisely at
//  stage COMMIT: a Moore FSM raises the CP0 pulses, squashes the trapping instruction and
//  all younger ones, then holds off new issue for HOLD_CYC cycles while fetch is redirected.
// PARAMETERS
//  CTRL_W   14  width of the decoded control bundle per stage
//  NSTG     3   number of pipeline stages after D (index 0=E, 1=M, 2=W)
//  COMMIT   1   stage index where exceptions are taken; legal range 0..NSTG-1
//  CAUSE_W  6   width of the CP0 cause code
//  HOLD_CYC 1   bubble cycles injected at stage 0 after a trap; 0 is legal
// PORTS
//  clk          in   1            clock; all state updates on the rising edge
//  rst          in   1            synchronous reset, active-high
//  validD       in   1            the decode-stage instruction is valid
//  ctrlD        in   CTRL_W       decoded control bundle
//  syscallD     in   1            SYSCALL detected in D
//  breakD       in   1            BREAK detected in D
//  riD          in   1            reserved instruction detected in D
//  eretD        in   1            ERET decoded in D
//  stall_i      in   NSTG         per-stage stall request
//  flush_i      in   NSTG         per-stage flush request
//  ctrl_o       out  NSTG*CTRL_W  stage k bundle at [k*CTRL_W +: CTRL_W]
//  valid_o      out  NSTG         per-stage valid
//  exception_o  out  1            one-cycle pulse to CP0 when an exception is taken
//  eret_o       out  1            one-cycle pulse to CP0 when an ERET is taken
//  cause_o      out  CAUSE_W      cause code of the last exception taken; holds its value
//  flush_all_o  out  1            one-cycle pulse; datapath flushes F/D and redirects PC
//  busy_o       out  1            FSM state is not RUN
// BEHAVIOUR
//  Reset (rst=1 at an edge):
//   - All valid bits and control bundles go to 0. All stage exc/eret tags go to 0.
//   - cause_o=0, hold counter=0, state=RUN.
//   - exception_o, eret_o, flush_all_o and busy_o are all 0 in the following cycle.
//  Tagging in D:
//   - exc = validD & (riD|syscallD|breakD).
//   - Cause priority: RI=10, then SYS=8, then BP=9.
//   - eret tag = validD & eretD & ~exc, so an exception beats an ERET.
//   - When validD=0 the bundle is captured as-is but the valid bit is 0 and both tags are 0.
//  Hold: h[k] = OR of stall_i[j] for j>=k. A stall in an older stage freezes all younger stages.
//  Per-stage update priority, highest first:
//   1. rst
//   2. flush: flush_i[k] or an internal squash. Clears valid, ctrl and tags.
//   3. h[k]=1: the stage holds its contents.
//   4. Capture from stage k-1; stage 0 captures from D.
//  Bubble rule: if h[k-1]=1 and h[k]=0, stage k captures a bubble (valid=0, ctrl=0).
//   Nothing is lost or duplicated across a stall.
//  Latency: with no stalls, a bundle captured from D at edge n appears on stage k at edge n+k.
//  Commit event, evaluated each cycle:
//   - Requires state=RUN, valid[COMMIT]=1, exc|eret tag set, h[COMMIT]=0, flush_i[COMMIT]=0.
//   - At that edge: state goes to TRAP and cause_o latches the stage cause.
//     Stages 0..COMMIT are cleared, so the trapping instruction never reaches COMMIT+1.
//     Stage COMMIT+1, if it exists, captures a bubble.
//   - If flush_i[COMMIT] and the exception arrive in the same cycle, the flush wins:
//     no exception is taken.
//  FSM (RUN, TRAP, HOLD), Moore outputs:
//   - RUN: stage 0 captures from D. Commit event goes to TRAP.
//   - TRAP (exactly 1 cycle):
//       exception_o=1 if the tag was exc, otherwise eret_o=1. flush_all_o=1, busy_o=1.
//       Stages 0..COMMIT are forced to bubbles; stall_i on those stages is ignored.
//       Stages >COMMIT advance under their normal stall rules, draining older instructions.
//       Next state is HOLD with cnt=HOLD_CYC-1, or RUN if HOLD_CYC=0.
//   - HOLD: stage 0 captures bubbles; busy_o=1. When cnt=0, go to RUN; otherwise cnt--.
//  Reset mid-TRAP or mid-HOLD returns to RUN in one edge. The trap is not re-raised.
//  No new commit event can be taken while state is not RUN.
// STRUCTURE
//  Shared package ctrl_pkg:
//   - Cause constants EXC_SYS=6'd8, EXC_BP=6'd9, EXC_RI=6'd10.
//   - FSM state encoding ST_RUN, ST_TRAP, ST_HOLD.
//  One sub-module: ctrl_stage_reg.
//   - Single stage: clk, rst, flush, hold, bubble, and data = {valid, eret, exc, cause, ctrl}.
//   - Instantiated NSTG times in a generate loop.
//  The FSM, hold vector and cause latch live in the top module.
// TESTING
//  1. Reset, then issue ctrlD=1,2,3,4 on consecutive cycles, no stalls.
//     -> valid_o[2]=1 carrying 1..4 on the 3rd..6th edges after issue; all pulses stay 0.
//  2. Set stall_i[1]=1 for 2 cycles while A is in M.
//     -> E and M hold; valid_o[2]=0 for 2 cycles; A then reaches W exactly once.
//  3. syscallD on B, followed by C and D; HOLD_CYC=1.
//     -> cycle after B is in M: exception_o=1, cause_o=8, flush_all_o=1.
//     -> B, C and D never reach W with valid=1; busy_o=1 for 2 cycles; E is valid 1 cycle later.
//  4. riD=syscallD=1 on the same instruction -> cause_o=10.
//     eretD alone -> eret_o=1, exception_o=0, cause_o unchanged.
//  5. Exception tag in M with flush_i[1]=1 in the same cycle.
//     -> no pulse, state stays RUN, valid_o[1]=0.
//  6. Assert rst during TRAP.
//     -> next cycle all outputs are 0, busy_o=0, and a new instruction issues normally.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared definitions for the control pipeline: CP0 cause codes, trap FSM
// encoding and the decode-side cause priority helper.
package ctrl_pkg;

   localparam logic [5:0] EXC_SYS = 6'd8;
   localparam logic [5:0] EXC_BP  = 6'd9;
   localparam logic [5:0] EXC_RI  = 6'd10;

   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_TRAP = 2'd1,
      ST_HOLD = 2'd2
   } state_e;

   // Reserved instruction outranks SYSCALL, which outranks BREAK.
   function automatic logic [5:0] cause_sel(input logic ri, input logic sys);
      logic [5:0] c;
      if (ri) begin
         c = EXC_RI;
      end else if (sys) begin
         c = EXC_SYS;
      end else begin
         c = EXC_BP;
      end
      return c;
   endfunction

endpackage

// File: rtl/ctrl_stage_reg.sv
// One pipeline stage of the control path. Priority: reset, flush, hold,
// bubble, capture.
module ctrl_stage_reg
   import ctrl_pkg::*;
#(
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush_i,
   input  logic          hold_i,
   input  logic          bubble_i,
   input  logic [DW-1:0] data_i,
   output logic [DW-1:0] data_o
);

   logic [DW-1:0] data_d;
   logic [DW-1:0] data_q;

   // Next-state selection for this stage.
   always_comb begin
      data_d = data_q;
      if (flush_i) begin
         data_d = {DW{1'b0}};
      end else if (hold_i) begin
         data_d = data_q;
      end else if (bubble_i) begin
         data_d = {DW{1'b0}};
      end else begin
         data_d = data_i;
      end
   end

   // Stage register.
   always_ff @(posedge clk) begin
      if (rst) begin
         data_q <= {DW{1'b0}};
      end else begin
         data_q <= data_d;
      end
   end

   assign data_o = data_q;

endmodule

// File: rtl/ctrl_pipe_exc.sv
// Control-signal pipeline after decode with precise exception / ERET handling
// at stage COMMIT and a short issue hold-off while fetch is redirected.
module ctrl_pipe_exc
   import ctrl_pkg::*;
#(
   parameter int CTRL_W   = 14,
   parameter int NSTG     = 3,
   parameter int COMMIT   = 1,
   parameter int CAUSE_W  = 6,
   parameter int HOLD_CYC = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     validD,
   input  logic [CTRL_W-1:0]        ctrlD,
   input  logic                     syscallD,
   input  logic                     breakD,
   input  logic                     riD,
   input  logic                     eretD,
   input  logic [NSTG-1:0]          stall_i,
   input  logic [NSTG-1:0]          flush_i,
   output logic [NSTG*CTRL_W-1:0]   ctrl_o,
   output logic [NSTG-1:0]          valid_o,
   output logic                     exception_o,
   output logic                     eret_o,
   output logic [CAUSE_W-1:0]       cause_o,
   output logic                     flush_all_o,
   output logic                     busy_o
);

   // Stage word layout: {valid, eret, exc, cause, ctrl}.
   localparam int DW    = 3 + CAUSE_W + CTRL_W;
   localparam int CNT_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                trap_exc_q, trap_exc_d;
   logic [CAUSE_W-1:0]  cause_q, cause_d;

   logic [DW-1:0]       stg_q  [NSTG];
   logic [DW-1:0]       stg_in [NSTG];
   logic [NSTG-1:0]     hold_s, flush_s, bubble_s;

   logic                exc_d_s, eret_d_s;
   logic [CAUSE_W-1:0]  cause_d_s;
   logic                com_valid_s, com_eret_s, com_exc_s, commit_s, in_trap_s;
   logic [CAUSE_W-1:0]  com_cause_s;
   logic                unused_tail_s;

   assign exc_d_s   = validD & (riD | syscallD | breakD);
   assign eret_d_s  = validD & eretD & ~exc_d_s;
   assign cause_d_s = exc_d_s ? CAUSE_W'(cause_sel(riD, syscallD)) : {CAUSE_W{1'b0}};

   // A stall in any older stage freezes this stage as well.
   always_comb begin
      hold_s[NSTG-1] = stall_i[NSTG-1];
      for (int k = NSTG - 2; k >= 0; k--) begin
         hold_s[k] = stall_i[k] | hold_s[k+1];
      end
   end

   assign com_valid_s = stg_q[COMMIT][DW-1];
   assign com_eret_s  = stg_q[COMMIT][DW-2];
   assign com_exc_s   = stg_q[COMMIT][DW-3];
   assign com_cause_s = stg_q[COMMIT][CTRL_W +: CAUSE_W];
   assign commit_s    = (state_q == ST_RUN) & com_valid_s & (com_exc_s | com_eret_s)
                        & ~hold_s[COMMIT] & ~flush_i[COMMIT];
   assign in_trap_s   = (state_q == ST_TRAP);

   genvar k;
   generate
      for (k = 0; k < NSTG; k++) begin : g_stg
         if (k == 0) begin : g_first
            assign stg_in[k]   = {validD, eret_d_s, exc_d_s, cause_d_s, ctrlD};
            assign bubble_s[k] = (state_q != ST_RUN);
         end else begin : g_rest
            assign stg_in[k] = stg_q[k-1];
            if (k == COMMIT + 1) begin : g_after_commit
               assign bubble_s[k] = hold_s[k-1] | commit_s;
            end else begin : g_plain
               assign bubble_s[k] = hold_s[k-1];
            end
         end
         // Stages up to COMMIT are squashed on the commit edge and throughout TRAP.
         if (k <= COMMIT) begin : g_squash
            assign flush_s[k] = flush_i[k] | commit_s | in_trap_s;
         end else begin : g_noquash
            assign flush_s[k] = flush_i[k];
         end

         ctrl_stage_reg #(.DW(DW)) u_stage (
            .clk      (clk),
            .rst      (rst),
            .flush_i  (flush_s[k]),
            .hold_i   (hold_s[k]),
            .bubble_i (bubble_s[k]),
            .data_i   (stg_in[k]),
            .data_o   (stg_q[k])
         );

         assign ctrl_o[k*CTRL_W +: CTRL_W] = stg_q[k][CTRL_W-1:0];
         assign valid_o[k]                 = stg_q[k][DW-1];
      end
   endgenerate

   assign unused_tail_s = ^stg_q[NSTG-1][DW-2:CTRL_W];

   // FSM state, hold counter, trap kind and cause latch.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_RUN;
         cnt_q      <= {CNT_W{1'b0}};
         trap_exc_q <= 1'b0;
         cause_q    <= {CAUSE_W{1'b0}};
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         trap_exc_q <= trap_exc_d;
         cause_q    <= cause_d;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      trap_exc_d = trap_exc_q;
      cause_d    = cause_q;
      case (state_q)
         ST_RUN: begin
            if (commit_s) begin
               state_d    = ST_TRAP;
               trap_exc_d = com_exc_s;
               cause_d    = com_exc_s ? com_cause_s : cause_q;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_TRAP: begin
            if (HOLD_CYC == 0) begin
               state_d = ST_RUN;
            end else begin
               state_d = ST_HOLD;
               cnt_d   = CNT_W'(HOLD_CYC - 1);
            end
         end
         ST_HOLD: begin
            if (cnt_q == {CNT_W{1'b0}}) begin
               state_d = ST_RUN;
            end else begin
               cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
            end
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

   // Moore outputs decoded from the state register.
   always_comb begin
      exception_o = 1'b0;
      eret_o      = 1'b0;
      flush_all_o = 1'b0;
      busy_o      = 1'b0;
      case (state_q)
         ST_RUN: begin
            busy_o = 1'b0;
         end
         ST_TRAP: begin
            exception_o = trap_exc_q;
            eret_o      = ~trap_exc_q;
            flush_all_o = 1'b1;
            busy_o      = 1'b1;
         end
         ST_HOLD: begin
            busy_o = 1'b1;
         end
         default: begin
            busy_o = 1'b0;
         end
      endcase
   end

   assign cause_o = cause_q;

endmodule

// File: tb/tb_ctrl_pipe_exc.sv
// Bench for ctrl_pipe_exc: directed scenarios plus random traffic, every
// cycle compared against a stage-array reference model.
module tb_ctrl_pipe_exc;

   localparam int CTRL_W   = 14;
   localparam int NSTG     = 3;
   localparam int COMMIT   = 1;
   localparam int CAUSE_W  = 6;
   localparam int HOLD_CYC = 1;

   logic                    clk;
   logic                    rst;
   logic                    validD;
   logic [CTRL_W-1:0]       ctrlD;
   logic                    syscallD, breakD, riD, eretD;
   logic [NSTG-1:0]         stall_i, flush_i;
   logic [NSTG*CTRL_W-1:0]  ctrl_o;
   logic [NSTG-1:0]         valid_o;
   logic                    exception_o, eret_o, flush_all_o, busy_o;
   logic [CAUSE_W-1:0]      cause_o;

   ctrl_pipe_exc #(
      .CTRL_W(CTRL_W), .NSTG(NSTG), .COMMIT(COMMIT),
      .CAUSE_W(CAUSE_W), .HOLD_CYC(HOLD_CYC)
   ) dut (
      .clk(clk), .rst(rst), .validD(validD), .ctrlD(ctrlD),
      .syscallD(syscallD), .breakD(breakD), .riD(riD), .eretD(eretD),
      .stall_i(stall_i), .flush_i(flush_i), .ctrl_o(ctrl_o), .valid_o(valid_o),
      .exception_o(exception_o), .eret_o(eret_o), .cause_o(cause_o),
      .flush_all_o(flush_all_o), .busy_o(busy_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d: got %0h want %0h", tag, cyc, obs, exp);
      end
   endtask

   // Reference model: one entry per stage; tag 0=none, 1=exception, 2=eret.
   bit                m_v     [NSTG];
   int                m_tag   [NSTG];
   int                m_cause [NSTG];
   logic [CTRL_W-1:0] m_ctrl  [NSTG];
   int                m_causeo;
   int                m_busy;
   bit                m_trap;
   bit                m_kind_exc;

   function automatic void model_edge();
      bit                h  [NSTG];
      bit                nv [NSTG];
      int                nt [NSTG];
      int                nc [NSTG];
      logic [CTRL_W-1:0] nx [NSTG];
      bit                commit;
      if (rst) begin
         for (int k = 0; k < NSTG; k++) begin
            m_v[k] = 0; m_tag[k] = 0; m_cause[k] = 0; m_ctrl[k] = '0;
         end
         m_causeo = 0; m_busy = 0; m_trap = 0; m_kind_exc = 0;
         return;
      end
      for (int k = 0; k < NSTG; k++) begin
         h[k] = 0;
         for (int j = k; j < NSTG; j++) if (stall_i[j]) h[k] = 1;
      end
      commit = (m_busy == 0) && m_v[COMMIT] && (m_tag[COMMIT] != 0)
               && !h[COMMIT] && !flush_i[COMMIT];
      for (int k = 0; k < NSTG; k++) begin
         nv[k] = 0; nt[k] = 0; nc[k] = 0; nx[k] = '0;
         if (flush_i[k] || (k <= COMMIT && (commit || m_trap))) begin
            nv[k] = 0;
         end else if (h[k]) begin
            nv[k] = m_v[k]; nt[k] = m_tag[k]; nc[k] = m_cause[k]; nx[k] = m_ctrl[k];
         end else if (k == 0) begin
            if (m_busy == 0) begin
               nx[k] = ctrlD;
               if (validD) begin
                  nv[k] = 1;
                  if (riD || syscallD || breakD) begin
                     nt[k] = 1;
                     nc[k] = riD ? 10 : (syscallD ? 8 : 9);
                  end else if (eretD) begin
                     nt[k] = 2;
                  end
               end
            end
         end else if (h[k-1] || (commit && k == COMMIT + 1)) begin
            nv[k] = 0;
         end else begin
            nv[k] = m_v[k-1]; nt[k] = m_tag[k-1]; nc[k] = m_cause[k-1]; nx[k] = m_ctrl[k-1];
         end
      end
      if (commit) begin
         m_trap     = 1;
         m_busy     = HOLD_CYC + 1;
         m_kind_exc = (m_tag[COMMIT] == 1);
         if (m_tag[COMMIT] == 1) m_causeo = m_cause[COMMIT];
      end else if (m_busy > 0) begin
         m_busy--;
         m_trap = 0;
      end
      for (int k = 0; k < NSTG; k++) begin
         m_v[k] = nv[k]; m_tag[k] = nt[k]; m_cause[k] = nc[k]; m_ctrl[k] = nx[k];
      end
   endfunction

   task automatic compare_all();
      logic [NSTG*CTRL_W-1:0] ec;
      logic [NSTG-1:0]        ev;
      for (int k = 0; k < NSTG; k++) begin
         ec[k*CTRL_W +: CTRL_W] = m_ctrl[k];
         ev[k]                  = m_v[k];
      end
      chk("valid", valid_o, ev);
      chk("ctrl", ctrl_o, ec);
      chk("exception", exception_o, m_trap && m_kind_exc);
      chk("eret", eret_o, m_trap && !m_kind_exc);
      chk("flush_all", flush_all_o, m_trap);
      chk("busy", busy_o, m_busy > 0);
      chk("cause", cause_o, CAUSE_W'(m_causeo));
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      cyc++;
      @(negedge clk);
      compare_all();
   endtask

   task automatic idle();
      validD = 1'b0; ctrlD = '0;
      syscallD = 1'b0; breakD = 1'b0; riD = 1'b0; eretD = 1'b0;
   endtask

   task automatic issue(input int c, input bit sys, input bit brk, input bit ri, input bit er);
      validD = 1'b1; ctrlD = CTRL_W'(c);
      syscallD = sys; breakD = brk; riD = ri; eretD = er;
   endtask

   initial begin
      rst = 1'b1; stall_i = '0; flush_i = '0;
      idle();
      step(); step();
      rst = 1'b0;
      chk("rst_valid", valid_o, 3'b000);
      chk("rst_busy", busy_o, 1'b0);
      chk("rst_cause", cause_o, 6'd0);

      // Straight-line flow: 1..4 reach W on the third edge after issue.
      for (int i = 1; i <= 6; i++) begin
         if (i <= 4) issue(i, 0, 0, 0, 0); else idle();
         step();
         if (i >= 3) begin
            chk("t1_wvalid", valid_o[2], 1'b1);
            chk("t1_wctrl", ctrl_o[2*CTRL_W +: CTRL_W], CTRL_W'(i - 2));
         end
      end
      idle(); step();

      // Stall M for two cycles while A sits there.
      issue(5, 0, 0, 0, 0); step();
      issue(6, 0, 0, 0, 0); step();
      idle(); stall_i = 3'b010;
      step(); chk("t2_wbub", valid_o[2], 1'b0);
      step(); chk("t2_wbub", valid_o[2], 1'b0);
      stall_i = 3'b000;
      step();
      chk("t2_wvalid", valid_o[2], 1'b1);
      chk("t2_wctrl", ctrl_o[2*CTRL_W +: CTRL_W], 14'd5);
      step(); step();

      // SYSCALL on B followed by C and D.
      issue(7, 1, 0, 0, 0); step();
      issue(8, 0, 0, 0, 0); step();
      issue(9, 0, 0, 0, 0); step();
      chk("t3_exc", exception_o, 1'b1);
      chk("t3_cause", cause_o, 6'd8);
      chk("t3_flush", flush_all_o, 1'b1);
      idle(); step();
      chk("t3_busy", busy_o, 1'b1);
      chk("t3_wvalid", valid_o[2], 1'b0);
      step();
      chk("t3_idle", busy_o, 1'b0);
      step(); step();

      // RI beats SYSCALL; ERET leaves cause alone.
      issue(10, 1, 0, 1, 0); step();
      idle(); step(); step();
      chk("t4_cause", cause_o, 6'd10);
      step(); step(); step();
      issue(11, 0, 0, 0, 1); step();
      idle(); step(); step();
      chk("t4_eret", eret_o, 1'b1);
      chk("t4_noexc", exception_o, 1'b0);
      chk("t4_cause", cause_o, 6'd10);
      step(); step(); step();

      // Flush at COMMIT wins over the exception.
      issue(12, 0, 1, 0, 0); step();
      idle(); step();
      flush_i = 3'b010; step();
      flush_i = 3'b000;
      chk("t5_noexc", exception_o, 1'b0);
      chk("t5_busy", busy_o, 1'b0);
      chk("t5_mvalid", valid_o[1], 1'b0);
      step(); step();

      // Reset during TRAP.
      issue(13, 1, 0, 0, 0); step();
      idle(); step(); step();
      chk("t6_trap", flush_all_o, 1'b1);
      rst = 1'b1; step();
      rst = 1'b0;
      chk("t6_busy", busy_o, 1'b0);
      chk("t6_exc", exception_o, 1'b0);
      chk("t6_valid", valid_o, 3'b000);
      issue(14, 0, 0, 0, 0); step();
      chk("t6_evalid", valid_o[0], 1'b1);
      chk("t6_ectrl", ctrl_o[CTRL_W-1:0], 14'd14);

      // Random traffic.
      for (int n = 0; n < 1500; n++) begin
         rst      = ($urandom_range(0, 99) == 0);
         validD   = ($urandom_range(0, 3) != 0);
         ctrlD    = CTRL_W'($urandom);
         riD      = ($urandom_range(0, 11) == 0);
         syscallD = ($urandom_range(0, 9) == 0);
         breakD   = ($urandom_range(0, 11) == 0);
         eretD    = ($urandom_range(0, 8) == 0);
         for (int k = 0; k < NSTG; k++) begin
            stall_i[k] = ($urandom_range(0, 7) == 0);
            flush_i[k] = ($urandom_range(0, 15) == 0);
         end
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
